// File: rtl/mem_write_arbiter.sv
// Four-core front end for the shared four-port data RAM: passes accesses straight through,
// arbitrates same-address write collisions round-robin, and returns registered read-valid strobes.
module mem_write_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1,
  input  logic              req2,
  input  logic              req3,
  input  logic              req4,
  input  logic              we1,
  input  logic              we2,
  input  logic              we3,
  input  logic              we4,
  input  logic [ADDR_W-1:0] addr_c1,
  input  logic [ADDR_W-1:0] addr_c2,
  input  logic [ADDR_W-1:0] addr_c3,
  input  logic [ADDR_W-1:0] addr_c4,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  input  logic [DATA_W-1:0] wdata3,
  input  logic [DATA_W-1:0] wdata4,
  output logic              gnt1,
  output logic              gnt2,
  output logic              gnt3,
  output logic              gnt4,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] rdata3,
  output logic [DATA_W-1:0] rdata4,
  output logic              rvalid1,
  output logic              rvalid2,
  output logic              rvalid3,
  output logic              rvalid4,
  output logic              write_en1,
  output logic              write_en2,
  output logic              write_en3,
  output logic              write_en4,
  output logic              read_en1,
  output logic              read_en2,
  output logic              read_en3,
  output logic              read_en4,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3,
  output logic [ADDR_W-1:0] addr4,
  output logic [DATA_W-1:0] Data_in1,
  output logic [DATA_W-1:0] Data_in2,
  output logic [DATA_W-1:0] Data_in3,
  output logic [DATA_W-1:0] Data_in4,
  input  logic [DATA_W-1:0] Data_out1,
  input  logic [DATA_W-1:0] Data_out2,
  input  logic [DATA_W-1:0] Data_out3,
  input  logic [DATA_W-1:0] Data_out4,
  output logic [15:0]       conflict_cnt
);

  // Handshake: a core raises reqn with we/addr/wdata and holds all of them until it sees gntn=1;
  // the access completes at the rising edge that ends the granted cycle. No other flow control.

  logic [3:0]        req;
  logic [3:0]        we;
  logic [3:0]        wr;
  logic [3:0]        collide;
  logic [3:0]        beaten;
  logic [3:0]        win;
  logic [3:0]        gnt;
  logic [3:0]        write_en;
  logic [3:0]        read_en;
  logic [3:0]        rvalid_q;
  logic [ADDR_W-1:0] addr_c [4];
  logic [1:0]        ptr;
  logic [15:0]       cnt_q;
  logic              any_collision;

  assign req       = {req4, req3, req2, req1};
  assign we        = {we4, we3, we2, we1};
  assign wr        = req & we;
  assign addr_c[0] = addr_c1;
  assign addr_c[1] = addr_c2;
  assign addr_c[2] = addr_c3;
  assign addr_c[3] = addr_c4;

  // Distance of core idx from the current top-priority core (0 = wins every group it is in).
  function automatic logic [1:0] rank(input logic [1:0] idx, input logic [1:0] p);
    return idx - p;
  endfunction

  always_comb begin
    collide = '0;
    beaten  = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (i != j && wr[i] && wr[j] && addr_c[i] == addr_c[j]) begin
          collide[i] = 1'b1;
          if (rank(2'(j), ptr) < rank(2'(i), ptr)) beaten[i] = 1'b1;
        end
      end
    end
  end

  // Reads and lone writes always pass; within a collision group only the best-ranked member.
  assign win           = collide & ~beaten;
  assign gnt           = rst_n ? (req & (~collide | win)) : 4'b0000;
  assign write_en      = gnt & we;
  assign read_en       = gnt & ~we;
  assign any_collision = |collide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= 2'd0;
      cnt_q    <= 16'd0;
      rvalid_q <= 4'b0000;
    end else begin
      rvalid_q <= read_en;
      if (any_collision) begin
        ptr <= ptr + 2'd1;
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign {gnt4, gnt3, gnt2, gnt1}                     = gnt;
  assign {write_en4, write_en3, write_en2, write_en1} = write_en;
  assign {read_en4, read_en3, read_en2, read_en1}     = read_en;
  assign {rvalid4, rvalid3, rvalid2, rvalid1}         = rvalid_q;
  assign conflict_cnt = cnt_q;

  assign addr1    = addr_c1;
  assign addr2    = addr_c2;
  assign addr3    = addr_c3;
  assign addr4    = addr_c4;
  assign Data_in1 = wdata1;
  assign Data_in2 = wdata2;
  assign Data_in3 = wdata3;
  assign Data_in4 = wdata4;
  assign rdata1   = Data_out1;
  assign rdata2   = Data_out2;
  assign rdata3   = Data_out3;
  assign rdata4   = Data_out4;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Bench for mem_write_arbiter: behavioural four-port RAM, scripted scenarios and randomized
// traffic checked against a grant/pointer/memory reference model.
module tb_mem_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  t_req;
  logic [3:0]  t_we;
  logic [8:0]  t_addr [4];
  logic [15:0] t_wdata [4];

  logic [3:0]  gnt_v, rvalid_v, wen_v, ren_v;
  logic [15:0] rdata_v [4];
  logic [15:0] din_v [4];
  logic [15:0] dout_v [4];
  logic [8:0]  ram_addr [4];
  logic [15:0] cnt_v;

  int errors;
  int checks;

  // Reference model state
  int          ptr_m;
  int          cnt_m;
  logic [3:0]  exp_rv;
  logic [15:0] mref [512];
  logic [15:0] exp_q [4][$];

  // Behavioural RAM: registered read address, combinational array read (write-first).
  logic [15:0] ram [512];
  logic [8:0]  rq [4];

  always @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (wen_v[p]) ram[ram_addr[p]] <= din_v[p];
      if (ren_v[p]) rq[p] <= ram_addr[p];
    end
  end
  assign dout_v[0] = ram[rq[0]];
  assign dout_v[1] = ram[rq[1]];
  assign dout_v[2] = ram[rq[2]];
  assign dout_v[3] = ram[rq[3]];

  mem_write_arbiter #(.ADDR_W(9), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req1(t_req[0]), .req2(t_req[1]), .req3(t_req[2]), .req4(t_req[3]),
    .we1(t_we[0]), .we2(t_we[1]), .we3(t_we[2]), .we4(t_we[3]),
    .addr_c1(t_addr[0]), .addr_c2(t_addr[1]), .addr_c3(t_addr[2]), .addr_c4(t_addr[3]),
    .wdata1(t_wdata[0]), .wdata2(t_wdata[1]), .wdata3(t_wdata[2]), .wdata4(t_wdata[3]),
    .gnt1(gnt_v[0]), .gnt2(gnt_v[1]), .gnt3(gnt_v[2]), .gnt4(gnt_v[3]),
    .rdata1(rdata_v[0]), .rdata2(rdata_v[1]), .rdata3(rdata_v[2]), .rdata4(rdata_v[3]),
    .rvalid1(rvalid_v[0]), .rvalid2(rvalid_v[1]), .rvalid3(rvalid_v[2]), .rvalid4(rvalid_v[3]),
    .write_en1(wen_v[0]), .write_en2(wen_v[1]), .write_en3(wen_v[2]), .write_en4(wen_v[3]),
    .read_en1(ren_v[0]), .read_en2(ren_v[1]), .read_en3(ren_v[2]), .read_en4(ren_v[3]),
    .addr1(ram_addr[0]), .addr2(ram_addr[1]), .addr3(ram_addr[2]), .addr4(ram_addr[3]),
    .Data_in1(din_v[0]), .Data_in2(din_v[1]), .Data_in3(din_v[2]), .Data_in4(din_v[3]),
    .Data_out1(dout_v[0]), .Data_out2(dout_v[1]), .Data_out3(dout_v[2]), .Data_out4(dout_v[3]),
    .conflict_cnt(cnt_v)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      ram[i]  = 16'h0000;
      mref[i] = 16'h0000;
    end
    for (int p = 0; p < 4; p++) rq[p] = 9'h000;
  end

  // Driver tasks
  task automatic clear_inputs();
    t_req = 4'b0000;
    t_we  = 4'b0000;
    for (int p = 0; p < 4; p++) begin
      t_addr[p]  = 9'h000;
      t_wdata[p] = 16'h0000;
    end
  endtask

  task automatic set_core(input int n, input logic r, input logic w, input logic [8:0] a,
                          input logic [15:0] d);
    t_req[n]   = r;
    t_we[n]    = w;
    t_addr[n]  = a;
    t_wdata[n] = d;
  endtask

  task automatic model_reset();
    ptr_m  = 0;
    cnt_m  = 0;
    exp_rv = 4'b0000;
    for (int p = 0; p < 4; p++) exp_q[p].delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  // Expected grants: every read, every lone write, and per same-address write group the
  // first member met scanning cores from ptr_m upward with wraparound.
  function automatic logic [3:0] model_grants(output logic coll);
    logic [3:0] g;
    int members;
    int idx;
    g = 4'b0000;
    coll = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (t_req[n] && !t_we[n]) g[n] = 1'b1;
      if (t_req[n] && t_we[n]) begin
        members = 0;
        for (int m = 0; m < 4; m++)
          if (t_req[m] && t_we[m] && t_addr[m] == t_addr[n]) members++;
        if (members == 1) g[n] = 1'b1;
        else begin
          coll = 1'b1;
          for (int k = 0; k < 4; k++) begin
            idx = (ptr_m + k) % 4;
            if (t_req[idx] && t_we[idx] && t_addr[idx] == t_addr[n]) begin
              if (idx == n) g[n] = 1'b1;
              break;
            end
          end
        end
      end
    end
    return g;
  endfunction

  // One clock cycle with the currently driven inputs; checks registered outputs at the
  // negedge, combinational outputs 1 ns later, then advances the model at the posedge.
  task automatic step(output logic [3:0] g_obs, output logic [3:0] g_mod);
    logic [3:0]  g;
    logic        coll;
    logic [15:0] e;
    @(negedge clk);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (rvalid_v[n] !== exp_rv[n]) begin
        errors++;
        $display("FAIL rvalid core%0d got=%b exp=%b t=%0t", n + 1, rvalid_v[n], exp_rv[n], $time);
      end
      if (exp_rv[n]) begin
        checks++;
        if (exp_q[n].size() == 0) begin
          errors++;
          $display("FAIL rdata_queue core%0d got=empty exp=entry t=%0t", n + 1, $time);
        end else begin
          e = exp_q[n].pop_front();
          if (rdata_v[n] !== e) begin
            errors++;
            $display("FAIL rdata core%0d got=%h exp=%h t=%0t", n + 1, rdata_v[n], e, $time);
          end
        end
      end
    end
    checks++;
    if (cnt_v !== 16'(cnt_m)) begin
      errors++;
      $display("FAIL conflict_cnt got=%0d exp=%0d t=%0t", cnt_v, cnt_m, $time);
    end
    #1;
    g = model_grants(coll);
    g_obs = gnt_v;
    g_mod = g;
    checks++;
    if (gnt_v !== g) begin
      errors++;
      $display("FAIL gnt got=%b exp=%b ptr=%0d t=%0t", gnt_v, g, ptr_m, $time);
    end
    checks++;
    if (wen_v !== (g & t_we) || ren_v !== (g & ~t_we)) begin
      errors++;
      $display("FAIL enables got=w%b/r%b exp=w%b/r%b t=%0t", wen_v, ren_v, g & t_we, g & ~t_we, $time);
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (ram_addr[n] !== t_addr[n] || din_v[n] !== t_wdata[n]) begin
        errors++;
        $display("FAIL passthru core%0d got=%h/%h exp=%h/%h", n + 1, ram_addr[n], din_v[n], t_addr[n], t_wdata[n]);
      end
    end
    @(posedge clk);
    for (int n = 0; n < 4; n++)
      if (g[n] && t_we[n]) mref[t_addr[n]] = t_wdata[n];
    for (int n = 0; n < 4; n++)
      if (g[n] && !t_we[n]) exp_q[n].push_back(mref[t_addr[n]]);
    exp_rv = g & ~t_we;
    if (coll) begin
      ptr_m = (ptr_m + 1) % 4;
      if (cnt_m != 65535) cnt_m++;
    end
    #1;
  endtask

  // Scenario tasks
  task automatic test_reset();
    rst_n = 1'b0;
    t_req = 4'b1111;
    t_we  = 4'b0101;
    for (int p = 0; p < 4; p++) begin
      t_addr[p]  = 9'h033;
      t_wdata[p] = 16'h5555;
    end
    @(negedge clk);
    #1;
    checks++;
    if (gnt_v !== 4'b0000 || wen_v !== 4'b0000 || ren_v !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gates got=g%b w%b r%b exp=0", gnt_v, wen_v, ren_v);
    end
    checks++;
    if (rvalid_v !== 4'b0000 || cnt_v !== 16'd0) begin
      errors++;
      $display("FAIL reset_regs got=rv%b cnt%0d exp=0", rvalid_v, cnt_v);
    end
    do_reset();
  endtask

  task automatic test_independent();
    logic [3:0] go, gm;
    do_reset();
    set_core(0, 1'b1, 1'b1, 9'h010, 16'h1234);
    set_core(1, 1'b1, 1'b0, 9'h011, 16'h0000);
    set_core(2, 1'b1, 1'b0, 9'h012, 16'h0000);
    set_core(3, 1'b1, 1'b0, 9'h013, 16'h0000);
    step(go, gm);
    checks++;
    if (go !== 4'b1111) begin
      errors++;
      $display("FAIL indep_gnt got=%b exp=1111", go);
    end
    checks++;
    if (rvalid_v !== 4'b1110) begin
      errors++;
      $display("FAIL indep_rvalid got=%b exp=1110", rvalid_v);
    end
    clear_inputs();
    set_core(1, 1'b1, 1'b0, 9'h010, 16'h0000);
    step(go, gm);
    clear_inputs();
    step(go, gm);
    checks++;
    if (rdata_v[1] !== 16'h1234 || cnt_v !== 16'd0) begin
      errors++;
      $display("FAIL indep_readback got=%h cnt=%0d exp=1234 cnt=0", rdata_v[1], cnt_v);
    end
  endtask

  task automatic test_two_way();
    logic [3:0] go, gm;
    do_reset();
    set_core(1, 1'b1, 1'b1, 9'h05A, 16'hAAAA);
    set_core(2, 1'b1, 1'b1, 9'h05A, 16'hBBBB);
    step(go, gm);
    checks++;
    if (go !== 4'b0010 || cnt_v !== 16'd1) begin
      errors++;
      $display("FAIL two_way_c0 got=%b cnt=%0d exp=0010 cnt=1", go, cnt_v);
    end
    set_core(1, 1'b0, 1'b0, 9'h000, 16'h0000);
    step(go, gm);
    checks++;
    if (go !== 4'b0100) begin
      errors++;
      $display("FAIL two_way_c1 got=%b exp=0100", go);
    end
    clear_inputs();
    set_core(0, 1'b1, 1'b0, 9'h05A, 16'h0000);
    step(go, gm);
    clear_inputs();
    step(go, gm);
    checks++;
    if (rdata_v[0] !== 16'hBBBB) begin
      errors++;
      $display("FAIL two_way_final got=%h exp=bbbb", rdata_v[0]);
    end
    // ptr should now be 1: a 1-vs-2 collision goes to core 2.
    clear_inputs();
    set_core(0, 1'b1, 1'b1, 9'h0A0, 16'h0001);
    set_core(1, 1'b1, 1'b1, 9'h0A0, 16'h0002);
    step(go, gm);
    checks++;
    if (go !== 4'b0010) begin
      errors++;
      $display("FAIL two_way_ptr got=%b exp=0010", go);
    end
  endtask

  task automatic test_four_way();
    logic [3:0] go, gm;
    logic [3:0] pend;
    logic [3:0] exp_order [4];
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000;
    do_reset();
    pend = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int n = 0; n < 4; n++) set_core(n, pend[n], 1'b1, 9'h1FF, 16'(n + 1));
      step(go, gm);
      checks++;
      if (go !== exp_order[c]) begin
        errors++;
        $display("FAIL four_way_c%0d got=%b exp=%b", c, go, exp_order[c]);
      end
      pend = pend & ~go;
    end
    checks++;
    if (cnt_v !== 16'd3) begin
      errors++;
      $display("FAIL four_way_cnt got=%0d exp=3", cnt_v);
    end
    clear_inputs();
    set_core(2, 1'b1, 1'b0, 9'h1FF, 16'h0000);
    step(go, gm);
    clear_inputs();
    step(go, gm);
    checks++;
    if (rdata_v[2] !== 16'h0004) begin
      errors++;
      $display("FAIL four_way_data got=%h exp=0004", rdata_v[2]);
    end
  endtask

  task automatic test_disjoint();
    logic [3:0] go, gm;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      clear_inputs();
      set_core(0, 1'b1, 1'b1, 9'h000, 16'h0011);
      set_core(1, 1'b1, 1'b1, 9'h000, 16'h0022);
      step(go, gm);
    end
    clear_inputs();
    set_core(0, 1'b1, 1'b1, 9'h020, 16'h0101);
    set_core(1, 1'b1, 1'b1, 9'h020, 16'h0202);
    set_core(2, 1'b1, 1'b1, 9'h030, 16'h0303);
    set_core(3, 1'b1, 1'b1, 9'h030, 16'h0404);
    step(go, gm);
    checks++;
    if (go !== 4'b0101) begin
      errors++;
      $display("FAIL disjoint_c0 got=%b exp=0101", go);
    end
    t_req = t_req & ~go;
    step(go, gm);
    checks++;
    if (go !== 4'b1010 || cnt_v !== 16'd3) begin
      errors++;
      $display("FAIL disjoint_c1 got=%b cnt=%0d exp=1010 cnt=3", go, cnt_v);
    end
  endtask

  task automatic test_rw_same();
    logic [3:0] go, gm;
    do_reset();
    set_core(0, 1'b1, 1'b1, 9'h100, 16'h0F0F);
    set_core(3, 1'b1, 1'b0, 9'h100, 16'h0000);
    step(go, gm);
    checks++;
    if (go !== 4'b1001 || rvalid_v[3] !== 1'b1 || rdata_v[3] !== 16'h0F0F) begin
      errors++;
      $display("FAIL rw_same got=g%b rv%b d%h exp=g1001 rv1 d0f0f", go, rvalid_v[3], rdata_v[3]);
    end
    clear_inputs();
    step(go, gm);
  endtask

  task automatic test_async_reset();
    logic [3:0] go, gm;
    do_reset();
    @(negedge clk);
    set_core(0, 1'b1, 1'b0, 9'h010, 16'h0000);
    #1;
    checks++;
    if (ren_v !== 4'b0001) begin
      errors++;
      $display("FAIL async_pre got=%b exp=0001", ren_v);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_v !== 4'b0000 || ren_v !== 4'b0000) begin
      errors++;
      $display("FAIL async_drop got=g%b r%b exp=0", gnt_v, ren_v);
    end
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (rvalid_v !== 4'b0000) begin
      errors++;
      $display("FAIL async_rvalid got=%b exp=0000", rvalid_v);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Pending rvalid already registered when reset hits.
    set_core(0, 1'b1, 1'b0, 9'h010, 16'h0000);
    step(go, gm);
    checks++;
    if (rvalid_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL async_pending_set got=%b exp=1", rvalid_v[0]);
    end
    rst_n = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (rvalid_v !== 4'b0000 || cnt_v !== 16'd0) begin
      errors++;
      $display("FAIL async_pending_lost got=rv%b cnt%0d exp=0", rvalid_v, cnt_v);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) set_core(n, 1'b1, 1'b1, 9'h0C0, 16'(16'h00C0 + n));
    step(go, gm);
    checks++;
    if (go !== 4'b0001 || cnt_v !== 16'd1) begin
      errors++;
      $display("FAIL async_ptr0 got=%b cnt=%0d exp=0001 cnt=1", go, cnt_v);
    end
    clear_inputs();
    step(go, gm);
  endtask

  task automatic test_random();
    logic [3:0] go, gm;
    logic [3:0] pend;
    logic [8:0] pool [4];
    pool[0] = 9'h040;
    pool[1] = 9'h041;
    pool[2] = 9'h042;
    pool[3] = 9'h1FE;
    do_reset();
    pend = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 4; n++) begin
        if (!pend[n] && $urandom_range(0, 9) < 7) begin
          pend[n] = 1'b1;
          set_core(n, 1'b1, 1'($urandom_range(0, 2) != 0), pool[$urandom_range(0, 3)],
                   16'($urandom_range(0, 65535)));
        end
        if (!pend[n]) t_req[n] = 1'b0;
      end
      step(go, gm);
      pend = pend & ~gm;
    end
    clear_inputs();
    step(go, gm);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clear_inputs();
    model_reset();
    test_reset();
    test_independent();
    test_two_way();
    test_four_way();
    test_disjoint();
    test_rw_same();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
